sync_frame_tx: RTL and testbench



---
 rtl/sync_frame_tx_pkg.sv | 8 +
 rtl/sync_frame_tx_if.sv | 11 +
 rtl/sync_frame_tx_bit_timer.sv | 19 +
 rtl/sync_frame_tx.sv | 75 +++++++
 tb/tb_sync_frame_tx.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/sync_frame_tx_pkg.sv
// sync_frame_tx_pkg: shared state encoding, default sync pattern and width helper
package sync_frame_tx_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, PARITY = 2'd3} state_t;
    localparam logic [3:0] SYNC_PAT_DEF = 4'b1011;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sync_frame_tx_if.sv
// sync_frame_tx_if: producer-side start/data handshake and serial line outputs
interface sync_frame_tx_if #(parameter int DATA_W = 8);
    logic start;
    logic [DATA_W-1:0] data_in;
    logic tx_bit;
    logic tx_valid;
    logic busy;
    logic done;
    modport master (output start, data_in, input tx_bit, tx_valid, busy, done);
    modport slave (input start, data_in, output tx_bit, tx_valid, busy, done);
endinterface

// File: rtl/sync_frame_tx_bit_timer.sv
// sync_frame_tx_bit_timer: ticks once every CYCLES_PER_BIT enabled cycles, cleared while disabled
module sync_frame_tx_bit_timer
    import sync_frame_tx_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);
    localparam int CW = cnt_w(CYCLES_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);
    logic [CW-1:0] cnt;
    assign bit_tick = en && cnt == LAST;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (!en || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sync_frame_tx.sv
// sync_frame_tx: sends sync pattern, MSB-first payload and optional even parity on one line
module sync_frame_tx
    import sync_frame_tx_pkg::*;
#(
    parameter int SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF),
    parameter int DATA_W = 8,
    parameter int CYCLES_PER_BIT = 1,
    parameter int PARITY_EN = 1
) (
    input logic clk,
    input logic rst,
    sync_frame_tx_if.slave bus
);
    localparam int FW = SYNC_W + DATA_W + 1;
    localparam int BW = cnt_w(SYNC_W > DATA_W ? SYNC_W : DATA_W);
    state_t state;
    logic [FW-1:0] fr;
    logic [BW-1:0] bcnt;
    logic tick, fin, tx_bit, tx_valid, busy, done;
    assign bus.tx_bit = tx_bit;
    assign bus.tx_valid = tx_valid;
    assign bus.busy = busy;
    assign bus.done = done;
    assign fin = tick && (state == PARITY || (state == DATA && bcnt == '0 && PARITY_EN == 0));
    sync_frame_tx_bit_timer #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_timer (
        .clk(clk),
        .rst(rst),
        .en(state != IDLE),
        .bit_tick(tick)
    );
    // whole frame lives in one shift register; the parity slot is simply never sent when disabled
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            fr <= '0;
            bcnt <= '0;
            tx_bit <= 1'b0;
            tx_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fin) begin
                state <= IDLE;
                tx_bit <= 1'b0;
                tx_valid <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end else case (state)
                IDLE: if (bus.start) begin
                    state <= SYNC;
                    fr <= {SYNC_PAT, bus.data_in, ^bus.data_in};
                    bcnt <= BW'(SYNC_W - 1);
                    tx_bit <= SYNC_PAT[SYNC_W-1];
                    tx_valid <= 1'b1;
                    busy <= 1'b1;
                end
                SYNC, DATA, PARITY: if (tick) begin
                    fr <= fr << 1;
                    tx_bit <= fr[FW-2];
                    if (bcnt == '0) begin
                        state <= (state == SYNC) ? DATA : PARITY;
                        bcnt <= BW'(DATA_W - 1);
                    end else bcnt <= bcnt - 1'b1;
                end
                default: begin
                    state <= IDLE;
                    tx_bit <= 1'b0;
                    tx_valid <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_sync_frame_tx.sv
// tb_sync_frame_tx: table, random and corner-case checks of sync_frame_tx in three configurations
module tb_sync_frame_tx;
    import sync_frame_tx_pkg::*;
    typedef struct {
        logic [7:0] d;
        logic [12:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    bit exp_q[$];
    vec_t tbl[5];
    always #5 clk = ~clk;
    sync_frame_tx_if #(.DATA_W(8)) a ();
    sync_frame_tx_if #(.DATA_W(8)) b ();
    sync_frame_tx_if #(.DATA_W(8)) c ();
    sync_frame_tx dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    sync_frame_tx #(.CYCLES_PER_BIT(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
    sync_frame_tx #(.PARITY_EN(0)) dut_c (.clk(clk), .rst(rst), .bus(c.slave));
    function automatic logic [3:0] oa();
        return {a.tx_bit, a.tx_valid, a.busy, a.done};
    endfunction
    function automatic logic [3:0] ob();
        return {b.tx_bit, b.tx_valid, b.busy, b.done};
    endfunction
    function automatic logic [3:0] oc();
        return {c.tx_bit, c.tx_valid, c.busy, c.done};
    endfunction
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b want %b (tx_bit,tx_valid,busy,done)", nm, $time, act, exp);
        end
    endtask
    task automatic chk_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask
    // reference frame: sync pattern, payload MSB first, then even parity if enabled
    task automatic build(input logic [7:0] d, input bit pe);
        exp_q.delete();
        for (int i = 3; i >= 0; i--) exp_q.push_back(SYNC_PAT_DEF[i]);
        for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(bit'($countones(d) % 2));
    endtask
    task automatic frame_a(input logic [7:0] d, input logic [12:0] exp, output int hits);
        logic [3:0] w;
        w = 4'b0;
        hits = 0;
        a.start = 1'b1;
        a.data_in = d;
        @(negedge clk);
        a.start = 1'b0;
        a.data_in = 8'($urandom);
        for (int i = 12; i >= 0; i--) begin
            chk("frame_bit", oa(), {exp[i], 3'b110});
            w = {w[2:0], a.tx_bit};
            if (w == 4'b1011) hits++;
            @(negedge clk);
        end
        chk("frame_done", oa(), 4'b0001);
        @(negedge clk);
        chk("frame_idle", oa(), 4'b0000);
    endtask
    initial begin
        int hits;
        logic [7:0] d;
        logic [12:0] v;
        a.start = 1'b0; a.data_in = '0;
        b.start = 1'b0; b.data_in = '0;
        c.start = 1'b0; c.data_in = '0;
        tbl[0] = '{8'hA5, 13'b1011_10100101_0};
        tbl[1] = '{8'h07, 13'b1011_00000111_1};
        tbl[2] = '{8'h00, 13'b1011_00000000_0};
        tbl[3] = '{8'hFF, 13'b1011_11111111_0};
        tbl[4] = '{8'h80, 13'b1011_10000000_1};
        @(negedge clk);
        chk("reset_a", oa(), 4'b0000);
        chk("reset_b", ob(), 4'b0000);
        chk("reset_c", oc(), 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            frame_a(tbl[k].d, tbl[k].exp, hits);
            if (k == 0) chk_int("detector_hits", hits, 1);
        end
        repeat (20) begin
            d = 8'($urandom);
            build(d, 1'b1);
            for (int i = 0; i < 13; i++) v[12-i] = exp_q[i];
            frame_a(d, v, hits);
        end
        build(8'h3C, 1'b1);
        a.start = 1'b1;
        a.data_in = 8'h3C;
        @(negedge clk);
        a.start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            chk("ignore_bit", oa(), {exp_q[i], 3'b110});
            if (i == 4) begin a.start = 1'b1; a.data_in = 8'hFF; end
            if (i == 5) a.start = 1'b0;
            @(negedge clk);
        end
        chk("ignore_done", oa(), 4'b0001);
        repeat (15) begin
            @(negedge clk);
            chk("no_second", oa(), 4'b0000);
        end
        build(8'hC3, 1'b1);
        a.start = 1'b1;
        a.data_in = 8'hC3;
        @(negedge clk);
        a.start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst", oa(), {exp_q[6], 3'b110});
        #2 rst = 1'b1;
        #1 chk("async_rst", oa(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst", oa(), 4'b0000);
        end
        build(8'h5A, 1'b1);
        a.data_in = 8'h5A;
        a.start = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 13; i++) begin
                chk("held_bit", oa(), {exp_q[i], 3'b110});
                @(negedge clk);
            end
            chk("held_gap", oa(), 4'b0001);
            if (f == 1) a.start = 1'b0;
            @(negedge clk);
        end
        chk("held_stop", oa(), 4'b0000);
        build(8'h80, 1'b1);
        b.start = 1'b1;
        b.data_in = 8'h80;
        @(negedge clk);
        b.start = 1'b0;
        for (int i = 0; i < 39; i++) begin
            chk("cpb3_bit", ob(), {exp_q[i/3], 3'b110});
            @(negedge clk);
        end
        chk("cpb3_done", ob(), 4'b0001);
        build(8'h07, 1'b0);
        c.start = 1'b1;
        c.data_in = 8'h07;
        @(negedge clk);
        c.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("nopar_bit", oc(), {exp_q[i], 3'b110});
            @(negedge clk);
        end
        chk("nopar_done", oc(), 4'b0001);
        @(negedge clk);
        chk("nopar_idle", oc(), 4'b0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
